bridge_driver: RTL and testbench

BRIDGE_DRIVER -- requirements
Module: bridge_driver

---
 rtl/drsstc_pkg.sv | 36 +++
 rtl/sync2.sv | 18 +
 rtl/bridge_driver.sv | 176 +++++++++++++++++
 tb/tb_bridge_driver.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/drsstc_pkg.sv
// Shared types and cycle-count derivations for the DRSSTC bridge driver.
// Every counter width comes from cnt_w so no counter can wrap below its limit.
package drsstc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEAD,
    DRV_A,
    DRV_B,
    LOCK
  } state_t;

  // Latched stop request and whether over-current contributed to it
  typedef struct packed {
    logic pend;
    logic ocd;
  } stop_t;

  function automatic int unsigned cnt_w(input int unsigned v);
    return (v < 2) ? 1 : int'($clog2(v + 1));
  endfunction

  // Zero-length intervals are clamped to one cycle so the compare constants stay legal
  function automatic int unsigned dead_cyc(input int unsigned ns, input int unsigned mhz);
    int unsigned c;
    c = ns * mhz / 1000;
    return (c == 0) ? 1 : c;
  endfunction

  function automatic int unsigned us_cyc(input int unsigned us, input int unsigned mhz);
    int unsigned c;
    c = us * mhz;
    return (c == 0) ? 1 : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer; output follows the input after two clock edges.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] pipe = 2'b00;

  always_ff @(posedge clk) begin
    if (rst) pipe <= 2'b00;
    else     pipe <= {pipe[0], d};
  end

  assign q = pipe[1];

endmodule

// File: rtl/bridge_driver.sv
// Full-bridge gate driver for a DRSSTC: phase-locked leg switching with dead time,
// soft turn-off at current zero, burst length limit, phase-loss watchdog and OCD lockout.
module bridge_driver
  import drsstc_pkg::*;
#(
  parameter int unsigned CLK_MHZ   = 100,
  parameter int unsigned DEAD_NS   = 200,
  parameter int unsigned MAX_ON_US = 200,
  parameter int unsigned WDOG_US   = 20,
  parameter int unsigned HOLD_US   = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic phase,
  input  logic ocd_raw,
  output logic gd_a,
  output logic gd_b,
  output logic busy,
  output logic fault
);

  localparam int unsigned DEAD_CYC = dead_cyc(DEAD_NS, CLK_MHZ);
  localparam int unsigned MAX_CYC  = us_cyc(MAX_ON_US, CLK_MHZ);
  localparam int unsigned WDOG_CYC = us_cyc(WDOG_US, CLK_MHZ);
  localparam int unsigned HOLD_CYC = us_cyc(HOLD_US, CLK_MHZ);

  localparam int unsigned DW = cnt_w(DEAD_CYC);
  localparam int unsigned BW = cnt_w(MAX_CYC);
  localparam int unsigned WW = cnt_w(WDOG_CYC);
  localparam int unsigned HW = cnt_w(HOLD_CYC);

  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_CYC);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  state_t        state   = IDLE;
  stop_t         stop    = '0;
  logic          phase_q = 1'b0;
  logic [DW-1:0] dcnt    = '0;
  logic [BW-1:0] bcnt    = '0;
  logic [WW-1:0] wcnt    = '0;
  logic [HW-1:0] hcnt    = '0;
  logic          gd_a_q  = 1'b0;
  logic          gd_b_q  = 1'b0;
  logic          busy_q  = 1'b0;
  logic          fault_q = 1'b0;

  logic          ocd_s;
  logic          ph_edge;
  logic          ph_rise;
  logic          stop_now;
  logic          ocd_now;
  logic [BW-1:0] bcnt_inc;
  logic [WW-1:0] wcnt_inc;

  sync2 u_ocd_sync (
    .clk (clk),
    .rst (rst),
    .d   (ocd_raw),
    .q   (ocd_s)
  );

  assign ph_edge  = phase ^ phase_q;
  assign ph_rise  = phase & ~phase_q;
  // Current-cycle causes are folded in so a stop raised on the edge cycle itself is honoured
  assign stop_now = stop.pend | ~en | (bcnt == BURST_MAX) | ocd_s;
  assign ocd_now  = stop.ocd | ocd_s;
  assign bcnt_inc = (bcnt == BURST_MAX) ? bcnt : bcnt + 1'b1;
  assign wcnt_inc = (wcnt == WDOG_LAST) ? wcnt : wcnt + 1'b1;

  always_ff @(posedge clk) begin
    // Edge history runs through reset so a steady phase level never looks like an edge
    phase_q <= phase;
    if (rst) begin
      state   <= IDLE;
      stop    <= '0;
      dcnt    <= '0;
      bcnt    <= '0;
      wcnt    <= '0;
      hcnt    <= '0;
      gd_a_q  <= 1'b0;
      gd_b_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      wcnt <= ph_edge ? '0 : wcnt_inc;
      case (state)
        IDLE: begin
          bcnt <= '0;
          stop <= '0;
          if (ph_rise && en) begin
            state  <= DEAD;
            dcnt   <= '0;
            busy_q <= 1'b1;
          end
        end

        DEAD: begin
          bcnt      <= bcnt_inc;
          stop.pend <= stop_now;
          stop.ocd  <= ocd_now;
          if (dcnt == DEAD_LAST) begin
            state  <= phase ? DRV_A : DRV_B;
            gd_a_q <= phase;
            gd_b_q <= ~phase;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end

        DRV_A, DRV_B: begin
          bcnt      <= bcnt_inc;
          stop.pend <= stop_now;
          stop.ocd  <= ocd_now;
          if (ph_edge) begin
            gd_a_q <= 1'b0;
            gd_b_q <= 1'b0;
            if (stop_now) begin
              // Soft turn-off at the current zero; no dead interval follows
              busy_q <= 1'b0;
              stop   <= '0;
              bcnt   <= '0;
              if (ocd_now) begin
                state   <= LOCK;
                hcnt    <= '0;
                fault_q <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              state <= DEAD;
              dcnt  <= '0;
            end
          end else if (wcnt == WDOG_LAST) begin
            // Feedback lost: hard turn-off without waiting for an edge
            state   <= LOCK;
            gd_a_q  <= 1'b0;
            gd_b_q  <= 1'b0;
            busy_q  <= 1'b0;
            stop    <= '0;
            bcnt    <= '0;
            hcnt    <= '0;
            fault_q <= 1'b1;
          end
        end

        LOCK: begin
          bcnt <= '0;
          stop <= '0;
          if (hcnt == HOLD_LAST) begin
            state   <= IDLE;
            fault_q <= 1'b0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          gd_a_q  <= 1'b0;
          gd_b_q  <= 1'b0;
          busy_q  <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign gd_a  = gd_a_q;
  assign gd_b  = gd_b_q;
  assign busy  = busy_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_bridge_driver.sv
// Directed bench for bridge_driver at default parameters (100 MHz, 20/20000/2000/10000 cycles).
module tb_bridge_driver;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, phase = 1'b0, ocd_raw = 1'b0;
  logic gd_a, gd_b, busy, fault;
  int   n_chk = 0, n_pass = 0, cyc = 0, ovl = 0;

  bridge_driver dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .phase   (phase),
    .ocd_raw (ocd_raw),
    .gd_a    (gd_a),
    .gd_b    (gd_b),
    .busy    (busy),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (gd_a && gd_b) ovl++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic upto(input int t);
    while (cyc < t) tick(1);
  endtask

  initial begin
    int e, b;

    // power-up and reset
    tick(1);
    chk("pwrup_busy", busy, 0);
    chk("pwrup_gd", {gd_a, gd_b}, 0);
    rst = 1; tick(2); rst = 0; tick(1);
    chk("rst_gd", {gd_a, gd_b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);

    // 250 kHz alternation with dead time
    en = 1; tick(3);
    phase = 1; e = cyc;
    upto(e + 1);   chk("a_dead_busy", busy, 1); chk("a_dead_gd", {gd_a, gd_b}, 0);
    upto(e + 20);  chk("a_dead_end", {gd_a, gd_b}, 0);
    upto(e + 21);  chk("a_drv_a", {gd_a, gd_b}, 2'b10);
    upto(e + 200); phase = 0; e = cyc;
    upto(e + 1);   chk("a_fall_low", {gd_a, gd_b}, 0);
    upto(e + 20);  chk("a_fall_dead", {gd_a, gd_b}, 0);
    upto(e + 21);  chk("a_drv_b", {gd_a, gd_b}, 2'b01);
    upto(e + 200); phase = 1; e = cyc;
    upto(e + 21);  chk("a_drv_a2", {gd_a, gd_b}, 2'b10);
    upto(e + 200); phase = 0; e = cyc;
    upto(e + 10);  phase = 1;
    upto(e + 21);  chk("a_dead_ignore", {gd_a, gd_b}, 2'b10);

    // en falls mid half-cycle: leg holds, then soft stop without dead time
    upto(e + 100); en = 0;
    upto(e + 150); chk("b_en_hold", {gd_a, gd_b}, 2'b10); chk("b_en_busy", busy, 1);
    upto(e + 200); phase = 0; e = cyc;
    upto(e + 1);   chk("b_stop_gd", {gd_a, gd_b}, 0); chk("b_stop_busy", busy, 0);
    chk("b_stop_fault", fault, 0);
    upto(e + 25);  chk("b_no_dead_drive", {gd_a, gd_b}, 0);
    upto(e + 200); phase = 1; e = cyc;
    upto(e + 5);   chk("b_no_restart_en0", busy, 0);

    // reset mid DRV_B, then restart on next rising edge
    en = 1; phase = 0; tick(5); phase = 1; e = cyc;
    upto(e + 21);  chk("c_drv_a", {gd_a, gd_b}, 2'b10);
    upto(e + 200); phase = 0; e = cyc;
    upto(e + 21);  chk("c_drv_b", {gd_a, gd_b}, 2'b01);
    upto(e + 50);  rst = 1; tick(1);
    chk("c_rst_gd", {gd_a, gd_b}, 0); chk("c_rst_busy", busy, 0);
    rst = 0; tick(5);
    chk("c_idle", busy, 0);
    phase = 1; e = cyc;
    upto(e + 1);   chk("c_restart", busy, 1);

    // phase frozen high: watchdog lockout
    upto(e + 21);   chk("d_drv_a", {gd_a, gd_b}, 2'b10);
    upto(e + 2000); chk("d_wd_pre_gd", {gd_a, gd_b}, 2'b10); chk("d_wd_pre_fault", fault, 0);
    upto(e + 2001); chk("d_wd_gd", {gd_a, gd_b}, 0); chk("d_wd_fault", fault, 1);
    chk("d_wd_busy", busy, 0);
    upto(e + 5000); phase = 0;
    upto(e + 5200); phase = 1;
    upto(e + 5201); chk("d_lock_no_restart", busy, 0);
    upto(e + 12000); chk("d_hold_last", fault, 1);
    upto(e + 12001); chk("d_hold_done", fault, 0); chk("d_hold_busy", busy, 0);

    // ocd pulse mid DRV_A
    phase = 0; tick(5); phase = 1; e = cyc;
    upto(e + 21);  chk("e_drv_a", {gd_a, gd_b}, 2'b10);
    upto(e + 100); ocd_raw = 1; tick(1); ocd_raw = 0;
    upto(e + 150); chk("e_ocd_hold", {gd_a, gd_b}, 2'b10); chk("e_ocd_nofault", fault, 0);
    upto(e + 200); phase = 0; e = cyc;
    upto(e + 1);   chk("e_ocd_gd", {gd_a, gd_b}, 0); chk("e_ocd_busy", busy, 0);
    chk("e_ocd_fault", fault, 1);
    upto(e + 200); phase = 1;
    upto(e + 201); chk("e_lock_no_restart", busy, 0);
    upto(e + 10000); chk("e_hold_last", fault, 1);
    upto(e + 10001); chk("e_hold_done", fault, 0);

    // ocd together with en=0 is an ocd stop; reset clears lockout
    phase = 0; tick(5); phase = 1; e = cyc;
    upto(e + 21);  chk("f_drv_a", {gd_a, gd_b}, 2'b10);
    upto(e + 60);  en = 0; ocd_raw = 1; tick(1); ocd_raw = 0;
    upto(e + 200); phase = 0; e = cyc;
    upto(e + 1);   chk("f_ocd_en_fault", fault, 1); chk("f_ocd_en_gd", {gd_a, gd_b}, 0);
    tick(3); rst = 1; tick(1); rst = 0;
    chk("f_rst_lock_fault", fault, 0); chk("f_rst_lock_busy", busy, 0);

    // burst length limit
    en = 1; tick(5); phase = 1; b = cyc;
    for (int j = 1; j <= 100; j++) begin
      upto(b + 200 * j);
      phase = ~phase;
    end
    upto(b + 20021); chk("g_last_leg", {gd_a, gd_b}, 2'b10);
    upto(b + 20200); phase = 0;
    upto(b + 20201); chk("g_limit_gd", {gd_a, gd_b}, 0); chk("g_limit_busy", busy, 0);
    en = 0;
    upto(b + 20230); chk("g_limit_idle", busy, 0); chk("g_limit_idle_gd", {gd_a, gd_b}, 0);

    chk("no_overlap", ovl, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
